// File: rtl/common_bus_team1.sv
// Basic-computer common bus: a 3-bit select drives one source onto the bus, and registers load from it.
// Optional macro COMMON_BUS_TR_EN implements TR; when undefined, tr is tied to 0 and S=110 drives zero.
module common_bus_team1 #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        S,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic [5:0]        ld,
  input  logic [5:0]        inc,
  input  logic [5:0]        clr,
  input  logic              alu_ld,
  input  logic [WORD_W-1:0] alu_res,
  input  logic              mem_we,
  output logic [WORD_W-1:0] bus,
  output logic [ADDR_W-1:0] ar,
  output logic [ADDR_W-1:0] pc,
  output logic [WORD_W-1:0] dr,
  output logic [WORD_W-1:0] ac,
  output logic [WORD_W-1:0] ir,
  output logic [WORD_W-1:0] tr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_wr
);

  logic [ADDR_W-1:0] ar_q, ar_d, pc_q, pc_d;
  logic [WORD_W-1:0] dr_q, dr_d, ac_q, ac_d, ir_q, ir_d, tr_q, tr_d;

  always_comb begin
    bus = '0;
    case (S)
      3'b001:  bus = WORD_W'(ar_q);
      3'b010:  bus = WORD_W'(pc_q);
      3'b011:  bus = dr_q;
      3'b100:  bus = ac_q;
      3'b101:  bus = ir_q;
      3'b110:  bus = tr_q;
      3'b111:  bus = mem_rdata;
      default: bus = '0;
    endcase
  end

  // Each register: clr > ld > inc > hold; ld samples the pre-edge bus.
  always_comb begin
    ar_d = ar_q;
    if (clr[0])      ar_d = '0;
    else if (ld[0])  ar_d = bus[ADDR_W-1:0];
    else if (inc[0]) ar_d = ar_q + ADDR_W'(1);

    pc_d = pc_q;
    if (clr[1])      pc_d = '0;
    else if (ld[1])  pc_d = bus[ADDR_W-1:0];
    else if (inc[1]) pc_d = pc_q + ADDR_W'(1);

    dr_d = dr_q;
    if (clr[2])      dr_d = '0;
    else if (ld[2])  dr_d = bus;
    else if (inc[2]) dr_d = dr_q + WORD_W'(1);

    ac_d = ac_q;
    if (clr[3])      ac_d = '0;
    else if (alu_ld) ac_d = alu_res;
    else if (ld[3])  ac_d = bus;
    else if (inc[3]) ac_d = ac_q + WORD_W'(1);

    // IR has no clear or increment path.
    ir_d = ir_q;
    if (ld[4]) ir_d = bus;
  end

`ifdef COMMON_BUS_TR_EN
  always_comb begin
    tr_d = tr_q;
    if (clr[5])      tr_d = '0;
    else if (ld[5])  tr_d = bus;
    else if (inc[5]) tr_d = tr_q + WORD_W'(1);
  end
`else
  assign tr_d = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_q <= '0;
      pc_q <= '0;
      dr_q <= '0;
      ac_q <= '0;
      ir_q <= '0;
      tr_q <= '0;
    end else begin
      ar_q <= ar_d;
      pc_q <= pc_d;
      dr_q <= dr_d;
      ac_q <= ac_d;
      ir_q <= ir_d;
      tr_q <= tr_d;
    end
  end

  assign ar        = ar_q;
  assign pc        = pc_q;
  assign dr        = dr_q;
  assign ac        = ac_q;
  assign ir        = ir_q;
  assign tr        = tr_q;
  assign mem_addr  = ar_q;
  assign mem_wdata = bus;
  assign mem_wr    = mem_we;

endmodule

// File: tb/tb_common_bus_team1.sv
// Directed vector bench for common_bus_team1: table of bus transfers plus async-reset sequences.
module tb_common_bus_team1;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  S;
  logic [15:0] mem_rdata, alu_res;
  logic [5:0]  ld, inc, clr;
  logic        alu_ld, mem_we;
  logic [15:0] bus, dr, ac, ir, tr, mem_wdata;
  logic [11:0] ar, pc, mem_addr;
  logic        mem_wr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  common_bus_team1 #(.WORD_W(16), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .S(S), .mem_rdata(mem_rdata), .ld(ld), .inc(inc),
    .clr(clr), .alu_ld(alu_ld), .alu_res(alu_res), .mem_we(mem_we), .bus(bus),
    .ar(ar), .pc(pc), .dr(dr), .ac(ac), .ir(ir), .tr(tr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wr(mem_wr)
  );

`ifdef COMMON_BUS_TR_EN
  localparam logic [15:0] TRV = 16'h1234;
  localparam logic [15:0] TRI = 16'h0001;
`else
  localparam logic [15:0] TRV = 16'h0000;
  localparam logic [15:0] TRI = 16'h0000;
`endif

  typedef struct {
    logic [2:0]  s;
    logic [5:0]  ld, inc, clr;
    logic        alu_ld;
    logic [15:0] alu_res, rdata;
    logic        we;
    logic [15:0] ebus;
    logic [11:0] ear, epc;
    logic [15:0] edr, eac, eir, etr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [2:0] s, input logic [5:0] l, input logic [5:0] i,
                     input logic [5:0] c, input logic al, input logic [15:0] ar_res,
                     input logic [15:0] rd, input logic we, input logic [15:0] eb,
                     input logic [11:0] e_ar, input logic [11:0] e_pc, input logic [15:0] e_dr,
                     input logic [15:0] e_ac, input logic [15:0] e_ir, input logic [15:0] e_tr);
    vec_t v;
    v.s = s; v.ld = l; v.inc = i; v.clr = c; v.alu_ld = al; v.alu_res = ar_res;
    v.rdata = rd; v.we = we; v.ebus = eb; v.ear = e_ar; v.epc = e_pc;
    v.edr = e_dr; v.eac = e_ac; v.eir = e_ir; v.etr = e_tr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    S = 3'b000; ld = '0; inc = '0; clr = '0; alu_ld = 1'b0;
    alu_res = '0; mem_rdata = '0; mem_we = 1'b0;
  endtask

  task automatic chk_regs(input string tag, input logic [11:0] e_ar, input logic [11:0] e_pc,
                          input logic [15:0] e_dr, input logic [15:0] e_ac,
                          input logic [15:0] e_ir, input logic [15:0] e_tr);
    chk({tag, ".ar"}, 32'(ar), 32'(e_ar));
    chk({tag, ".pc"}, 32'(pc), 32'(e_pc));
    chk({tag, ".dr"}, 32'(dr), 32'(e_dr));
    chk({tag, ".ac"}, 32'(ac), 32'(e_ac));
    chk({tag, ".ir"}, 32'(ir), 32'(e_ir));
    chk({tag, ".tr"}, 32'(tr), 32'(e_tr));
  endtask

  initial begin
    logic [11:0] prev_ar;
    //   S       ld         inc        clr        al  alu_res   rdata     we  bus       ar      pc      dr        ac        ir        tr
    add(3'b111, 6'b010000, 6'b000000, 6'b000000, 0, 16'h0000, 16'h7123, 0, 16'h7123, 12'h000, 12'h000, 16'h0000, 16'h0000, 16'h7123, 16'h0);
    add(3'b101, 6'b000001, 6'b000000, 6'b000000, 0, 16'h0000, 16'h0000, 0, 16'h7123, 12'h123, 12'h000, 16'h0000, 16'h0000, 16'h7123, 16'h0);
    add(3'b001, 6'b000010, 6'b000000, 6'b000000, 0, 16'h0000, 16'h0000, 0, 16'h0123, 12'h123, 12'h123, 16'h0000, 16'h0000, 16'h7123, 16'h0);
    add(3'b111, 6'b001100, 6'b000000, 6'b000000, 0, 16'h0000, 16'hFFFF, 0, 16'hFFFF, 12'h123, 12'h123, 16'hFFFF, 16'hFFFF, 16'h7123, 16'h0);
    add(3'b000, 6'b000000, 6'b001000, 6'b000000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 12'h123, 12'h123, 16'hFFFF, 16'h0000, 16'h7123, 16'h0);
    add(3'b111, 6'b000010, 6'b000000, 6'b000000, 0, 16'h0000, 16'h0FFF, 0, 16'h0FFF, 12'h123, 12'hFFF, 16'hFFFF, 16'h0000, 16'h7123, 16'h0);
    add(3'b010, 6'b000000, 6'b000011, 6'b000000, 0, 16'h0000, 16'h0000, 0, 16'h0FFF, 12'h124, 12'h000, 16'hFFFF, 16'h0000, 16'h7123, 16'h0);
    add(3'b111, 6'b001100, 6'b000100, 6'b000100, 1, 16'h00AA, 16'h5500, 0, 16'h5500, 12'h124, 12'h000, 16'h0000, 16'h00AA, 16'h7123, 16'h0);
    add(3'b100, 6'b000001, 6'b000000, 6'b000000, 0, 16'h0000, 16'h0000, 1, 16'h00AA, 12'h0AA, 12'h000, 16'h0000, 16'h00AA, 16'h7123, 16'h0);
    add(3'b111, 6'b000001, 6'b000000, 6'b000000, 0, 16'h0000, 16'h0010, 0, 16'h0010, 12'h010, 12'h000, 16'h0000, 16'h00AA, 16'h7123, 16'h0);
    add(3'b111, 6'b001000, 6'b000000, 6'b000000, 0, 16'h0000, 16'hBEEF, 0, 16'hBEEF, 12'h010, 12'h000, 16'h0000, 16'hBEEF, 16'h7123, 16'h0);
    add(3'b100, 6'b000000, 6'b000000, 6'b000000, 0, 16'h0000, 16'h0000, 1, 16'hBEEF, 12'h010, 12'h000, 16'h0000, 16'hBEEF, 16'h7123, 16'h0);
    add(3'b100, 6'b001000, 6'b001000, 6'b000000, 0, 16'h0000, 16'h0000, 0, 16'hBEEF, 12'h010, 12'h000, 16'h0000, 16'hBEEF, 16'h7123, 16'h0);
    add(3'b110, 6'b100000, 6'b000000, 6'b000000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 12'h010, 12'h000, 16'h0000, 16'hBEEF, 16'h7123, 16'h0);
    add(3'b111, 6'b100000, 6'b000000, 6'b000000, 0, 16'h0000, 16'h1234, 0, 16'h1234, 12'h010, 12'h000, 16'h0000, 16'hBEEF, 16'h7123, TRV);
    add(3'b110, 6'b000100, 6'b000000, 6'b000000, 0, 16'h0000, 16'h0000, 0, TRV,      12'h010, 12'h000, TRV,      16'hBEEF, 16'h7123, TRV);
    add(3'b111, 6'b111111, 6'b000000, 6'b111111, 0, 16'h0000, 16'hFFFF, 0, 16'hFFFF, 12'h000, 12'h000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0);
    add(3'b000, 6'b000000, 6'b111111, 6'b000000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 12'h001, 12'h001, 16'h0001, 16'h0001, 16'hFFFF, TRI);

    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_regs("reset", 12'h0, 12'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    chk("reset.bus", 32'(bus), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    prev_ar = 12'h000;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      S = vecs[i].s; ld = vecs[i].ld; inc = vecs[i].inc; clr = vecs[i].clr;
      alu_ld = vecs[i].alu_ld; alu_res = vecs[i].alu_res; mem_rdata = vecs[i].rdata;
      mem_we = vecs[i].we;
      #1;
      chk($sformatf("v%0d.bus", i), 32'(bus), 32'(vecs[i].ebus));
      chk($sformatf("v%0d.mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].ebus));
      chk($sformatf("v%0d.mem_wr", i), 32'(mem_wr), 32'(vecs[i].we));
      chk($sformatf("v%0d.mem_addr", i), 32'(mem_addr), 32'(prev_ar));
      @(posedge clk);
      #1;
      chk_regs($sformatf("v%0d", i), vecs[i].ear, vecs[i].epc, vecs[i].edr,
               vecs[i].eac, vecs[i].eir, vecs[i].etr);
      prev_ar = vecs[i].ear;
    end

    // Async reset mid-cycle: registers must clear before any clock edge.
    @(negedge clk);
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk_regs("async_rst", 12'h0, 12'h0, 16'h0, 16'h0, 16'h0, 16'h0);

    // Strobes ignored while reset held; bus still shows mem_rdata for S=111.
    S = 3'b111; mem_rdata = 16'hA5A5; ld = 6'b111111; inc = 6'b111111; alu_ld = 1'b1;
    alu_res = 16'h0F0F;
    #1;
    chk("rst.bus_mem", 32'(bus), 32'hA5A5);
    @(posedge clk);
    #1;
    chk_regs("rst_hold", 12'h0, 12'h0, 16'h0, 16'h0, 16'h0, 16'h0);

    // First edge after release loads everything (AC takes alu_res).
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_regs("post_rst", 12'h5A5, 12'h5A5, 16'hA5A5, 16'h0F0F, 16'hA5A5,
`ifdef COMMON_BUS_TR_EN
             16'hA5A5);
`else
             16'h0000);
`endif

    @(negedge clk);
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
